// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared pipeline types for the MEM/WB stage. A lane_fields_t
//             holds one lane's registered write-back fields. Address and data
//             fields are sized for the widest supported configuration, and a
//             stage narrower than that zero-extends into them.
//  Contents : LANE_AW_MAX, LANE_DW_MAX, LANES_MAX, lane_fields_t,
//             LANE_FIELDS_RST (reset / flush value of a lane)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int LANE_AW_MAX = 8;   // widest supported REG_AW
   localparam int LANE_DW_MAX = 64;  // widest supported REG_DW
   localparam int LANES_MAX   = 8;   // widest supported LANES

   typedef struct packed {
      logic                   valid;
      logic                   wb_en;
      logic [LANE_AW_MAX-1:0] addr;
      logic [LANE_DW_MAX-1:0] data;
   } lane_fields_t;

   localparam lane_fields_t LANE_FIELDS_RST = '{valid: 1'b0, wb_en: 1'b0,
                                                addr: '0, data: '0};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/lane_popcount.sv
`default_nettype none
// ============================================================================
//  Module   : lane_popcount
//  Purpose  : Counts the set bits of a LANES-wide lane mask.
//  Ports    : bits  [LANES-1:0]  - lane mask
//             count [OUT_W-1:0]  - number of set bits, OUT_W = clog2(LANES+1)
//  Revision : 1.0 - initial release
// ============================================================================
module lane_popcount #(
   parameter  int LANES = 2,
   localparam int OUT_W = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0] bits,
   output logic [OUT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < LANES; i++) begin
         count = count + OUT_W'(bits[i]);
      end
   end

endmodule : lane_popcount
`default_nettype wire

// File: rtl/mem_wb_nway.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_nway
//  Purpose  : N-lane MEM/WB pipeline register with a retired-instruction
//             counter. Lane 0 is the oldest instruction. Edge priority is
//             rst > flush_i > stall_i > capture. Writes to register 0 are
//             suppressed; address and data are captured for every lane so
//             they stay visible even when the lane is inert.
//  Config   : MEM_WB_DEDUP_EN - when defined, an older lane's write enable is
//             dropped if a younger lane writes the same register in the same
//             bundle (younger wins, valid is untouched).
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             in_valid_i  [LANES]  - lane holds a real instruction
//             in_wb_en_i  [LANES]  - lane requests a register write
//             in_wb_addr_i[LANES*REG_AW], in_data_i[LANES*REG_DW]
//                                  - per-lane address/data, lane i at [i*W +: W]
//             stall_i, flush_i     - hold / kill the stage contents
//             wb_valid_o, wb_en_o, wb_addr_o, wb_data_o
//                                  - registered lane fields
//             retire_cnt_o [CNT_W] - wrap-around count of retired instructions
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_nway
   import pipe_pkg::*;
#(
   parameter int REG_DW = 32,
   parameter int REG_AW = 5,
   parameter int LANES  = 2,
   parameter int CNT_W  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LANES-1:0]        in_valid_i,
   input  logic [LANES-1:0]        in_wb_en_i,
   input  logic [LANES*REG_AW-1:0] in_wb_addr_i,
   input  logic [LANES*REG_DW-1:0] in_data_i,
   input  logic                    stall_i,
   input  logic                    flush_i,
   output logic [LANES-1:0]        wb_valid_o,
   output logic [LANES-1:0]        wb_en_o,
   output logic [LANES*REG_AW-1:0] wb_addr_o,
   output logic [LANES*REG_DW-1:0] wb_data_o,
   output logic [CNT_W-1:0]        retire_cnt_o
);

   localparam int PC_W = $clog2(LANES + 1);

   logic [LANES-1:0] qual;        // valid, write requested, destination != x0
   logic [LANES-1:0] wb_en_nxt;   // qual after optional same-address masking
   logic [PC_W-1:0]  retire_inc;
   lane_fields_t     lanes_q [LANES];
   logic [CNT_W-1:0] cnt_q;

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_qual
         assign qual[i] = in_valid_i[i] & in_wb_en_i[i]
                        & (|in_wb_addr_i[i*REG_AW +: REG_AW]);
      end
   endgenerate

   always_comb begin
      wb_en_nxt = qual;
`ifdef MEM_WB_DEDUP_EN
      // Any younger qualifying lane to the same register overrides lane i.
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (qual[i] && qual[j] &&
                (in_wb_addr_i[i*REG_AW +: REG_AW] == in_wb_addr_i[j*REG_AW +: REG_AW])) begin
               wb_en_nxt[i] = 1'b0;
            end
         end
      end
`endif
   end

   lane_popcount #(
      .LANES (LANES)
   ) u_popcount (
      .bits  (in_valid_i),
      .count (retire_inc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) lanes_q[i] <= LANE_FIELDS_RST;
         cnt_q <= '0;
      end else if (flush_i) begin
         // Flush kills the lanes but the instructions already counted stay counted.
         for (int i = 0; i < LANES; i++) lanes_q[i] <= LANE_FIELDS_RST;
      end else if (!stall_i) begin
         for (int i = 0; i < LANES; i++) begin
            lanes_q[i] <= '{valid: in_valid_i[i],
                            wb_en: wb_en_nxt[i],
                            addr:  LANE_AW_MAX'(in_wb_addr_i[i*REG_AW +: REG_AW]),
                            data:  LANE_DW_MAX'(in_data_i[i*REG_DW +: REG_DW])};
         end
         cnt_q <= cnt_q + CNT_W'(retire_inc);
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_out
         assign wb_valid_o[i]                   = lanes_q[i].valid;
         assign wb_en_o[i]                      = lanes_q[i].wb_en;
         assign wb_addr_o[i*REG_AW +: REG_AW]   = lanes_q[i].addr[REG_AW-1:0];
         assign wb_data_o[i*REG_DW +: REG_DW]   = lanes_q[i].data[REG_DW-1:0];
      end
   endgenerate

   assign retire_cnt_o = cnt_q;

endmodule : mem_wb_nway
`default_nettype wire

// File: tb/tb_mem_wb_nway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_nway
//  Purpose  : Self-checking bench for mem_wb_nway. Two instances share every
//             input: one with default parameters and one with a 4-bit retire
//             counter to exercise wrap-around. Each stimulus step queues its
//             hand-computed expected outputs; a monitor pops one entry after
//             every rising edge and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_nway;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  in_valid = '0;
   logic [1:0]  in_wb_en = '0;
   logic [9:0]  in_addr  = '0;
   logic [63:0] in_data  = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   logic [1:0]  wb_valid, wb_en, wb_valid4, wb_en4;
   logic [9:0]  wb_addr, wb_addr4;
   logic [63:0] wb_data, wb_data4;
   logic [63:0] cnt;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   mem_wb_nway dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_wb_en_i(in_wb_en),
      .in_wb_addr_i(in_addr), .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
      .wb_valid_o(wb_valid), .wb_en_o(wb_en), .wb_addr_o(wb_addr),
      .wb_data_o(wb_data), .retire_cnt_o(cnt)
   );

   mem_wb_nway #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_wb_en_i(in_wb_en),
      .in_wb_addr_i(in_addr), .in_data_i(in_data), .stall_i(stall), .flush_i(flush),
      .wb_valid_o(wb_valid4), .wb_en_o(wb_en4), .wb_addr_o(wb_addr4),
      .wb_data_o(wb_data4), .retire_cnt_o(cnt4)
   );

   typedef struct {
      string       name;
      logic [1:0]  v;
      logic [1:0]  en;
      logic [9:0]  addr;
      logic [63:0] data;
      logic [63:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

`ifdef MEM_WB_DEDUP_EN
   localparam logic [1:0] SAME_ADDR_EN = 2'b10;
`else
   localparam logic [1:0] SAME_ADDR_EN = 2'b11;
`endif

   function automatic logic [9:0] ap(input int l1, input int l0);
      return {5'(l1), 5'(l0)};
   endfunction

   function automatic logic [63:0] dp(input int l1, input int l0);
      return {32'(l1), 32'(l0)};
   endfunction

   task automatic chk(input string nm, input string fld,
                      input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
      end
   endtask

   // Monitor: one expectation is consumed per rising edge after it was queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "wb_valid",  64'(wb_valid),  64'(e.v));
            chk(e.name, "wb_en",     64'(wb_en),     64'(e.en));
            chk(e.name, "wb_addr",   64'(wb_addr),   64'(e.addr));
            chk(e.name, "wb_data",   wb_data,        e.data);
            chk(e.name, "retire",    cnt,            e.cnt);
            chk(e.name, "retire4",   64'(cnt4),      64'(e.cnt4));
            chk(e.name, "wb_en4",    64'(wb_en4),    64'(e.en));
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic s, input logic f,
                       input logic [1:0] v, input logic [1:0] e,
                       input logic [9:0] a, input logic [63:0] d,
                       input logic [1:0] xv, input logic [1:0] xe,
                       input logic [9:0] xa, input logic [63:0] xd,
                       input logic [63:0] xc, input logic [3:0] xc4);
      exp_t x;
      @(negedge clk);
      rst = r; stall = s; flush = f;
      in_valid = v; in_wb_en = e; in_addr = a; in_data = d;
      x.name = nm; x.v = xv; x.en = xe; x.addr = xa; x.data = xd;
      x.cnt = xc; x.cnt4 = xc4;
      exp_q.push_back(x);
   endtask

   initial begin
      // Reset wins over live inputs.
      step("reset", 1, 0, 0, 2'b11, 2'b11, ap(3,5), dp(1,2),
           2'b00, 2'b00, ap(0,0), dp(0,0), 0, 0);
      // Two-lane capture.
      step("cap2", 0, 0, 0, 2'b11, 2'b11, ap(3,5), dp('hA,'hB),
           2'b11, 2'b11, ap(3,5), dp('hA,'hB), 2, 2);
      // Lane0 writes x0 (suppressed), lane1 wants a write but is not valid.
      step("x0", 0, 0, 0, 2'b01, 2'b11, ap(4,0), dp('hC,'hD),
           2'b01, 2'b00, ap(4,0), dp('hC,'hD), 3, 3);
      step("lane1", 0, 0, 0, 2'b10, 2'b10, ap(9,1), dp('h11,'h22),
           2'b10, 2'b10, ap(9,1), dp('h11,'h22), 4, 4);
      // Stall for three cycles with changing inputs: everything frozen.
      for (int k = 0; k < 3; k++) begin
         step("stall", 0, 1, 0, 2'b11, 2'b11, ap(2+k,3+k), dp(k,k+1),
              2'b10, 2'b10, ap(9,1), dp('h11,'h22), 4, 4);
      end
      step("resume", 0, 0, 0, 2'b11, 2'b11, ap(6,8), dp('h33,'h44),
           2'b11, 2'b11, ap(6,8), dp('h33,'h44), 6, 6);
      // Flush together with stall acts as flush; count untouched.
      step("flushstall", 0, 1, 1, 2'b11, 2'b11, ap(1,2), dp(5,6),
           2'b00, 2'b00, ap(0,0), dp(0,0), 6, 6);
      // Idle bundle: nothing retires.
      step("idle", 0, 0, 0, 2'b00, 2'b11, ap(1,2), dp(7,8),
           2'b00, 2'b00, ap(1,2), dp(7,8), 6, 6);
      // Same destination in both lanes.
      step("sameaddr", 0, 0, 0, 2'b11, 2'b11, ap(7,7), dp(2,1),
           2'b11, SAME_ADDR_EN, ap(7,7), dp(2,1), 8, 8);
      step("flush", 0, 0, 1, 2'b11, 2'b11, ap(3,3), dp(9,9),
           2'b00, 2'b00, ap(0,0), dp(0,0), 8, 8);
      // Reset mid-stall clears the counter and discards the bundle.
      step("rststall", 1, 1, 0, 2'b11, 2'b11, ap(3,4), dp(1,1),
           2'b00, 2'b00, ap(0,0), dp(0,0), 0, 0);
      // Fifteen single-lane retires, then a two-lane retire wraps the 4-bit counter.
      for (int k = 1; k <= 15; k++) begin
         step("pre", 0, 0, 0, 2'b01, 2'b00, ap(0,0), dp(0,k),
              2'b01, 2'b00, ap(0,0), dp(0,k), 64'(k), 4'(k));
      end
      step("wrap", 0, 0, 0, 2'b11, 2'b11, ap(1,2), dp(3,4),
           2'b11, 2'b11, ap(1,2), dp(3,4), 17, 1);
      // Reset mid-flush.
      step("rstflush", 1, 0, 1, 2'b11, 2'b11, ap(1,2), dp(3,4),
           2'b00, 2'b00, ap(0,0), dp(0,0), 0, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_wb_nway
`default_nettype wire
